branch_compare_unit: RTL and testbench

Registered, parametrised branch-condition evaluator for the pipelined MIPS datapath. It replaces the bare 32-bit equality check with a six-way-plus-unsigned condition decoder, a one-cycle pipeline register with valid, stall and flush control, and optional saturating branch/taken statistics. It sits between operand forwarding and fetch-redirect logic: ID-stage operands go in, and a registered `taken` decision is returned one cycle later.

---
 rtl/branch_compare_unit.sv | 99 +++++++++
 tb/tb_branch_compare_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_compare_unit.sv
// Registered MIPS branch-condition evaluator; optional saturating stats under BRANCH_CMP_STATS_EN.
// Latency: 1 cycle, with no combinational path from inputs to outputs.
// Backpressure: stall holds every output; flush zeroes them and overrides stall.
module branch_compare_unit #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     data1,
    input  logic [WIDTH-1:0]     data2,
    input  logic                 stall,
    input  logic                 flush,
    output logic                 out_valid,
    output logic [2:0]           out_op,
    output logic                 isEqual,
    output logic                 isLess,
`ifdef BRANCH_CMP_STATS_EN
    input  logic                 cnt_clear,
    output logic [CNT_WIDTH-1:0] branch_count,
    output logic [CNT_WIDTH-1:0] taken_count,
`endif
    output logic                 taken
);

    localparam logic [2:0] OP_BEQ  = 3'd0;
    localparam logic [2:0] OP_BNE  = 3'd1;
    localparam logic [2:0] OP_BLEZ = 3'd2;
    localparam logic [2:0] OP_BGTZ = 3'd3;
    localparam logic [2:0] OP_BLTZ = 3'd4;
    localparam logic [2:0] OP_BGEZ = 3'd5;
    localparam logic [2:0] OP_BLTU = 3'd6;
    localparam logic [2:0] OP_BGEU = 3'd7;

    logic eq;
    logic lt_s;
    logic lt_u;
    logic d1_neg;
    logic d1_zero;
    logic cond;
    logic capture;

    always_comb begin
        eq      = (data1 == data2);
        lt_s    = ($signed(data1) < $signed(data2));
        lt_u    = (data1 < data2);
        d1_neg  = data1[WIDTH-1];
        d1_zero = (data1 == '0);
        cond    = 1'b0;
        case (op)
            OP_BEQ:  cond = eq;
            OP_BNE:  cond = !eq;
            OP_BLEZ: cond = d1_neg || d1_zero;
            OP_BGTZ: cond = !d1_neg && !d1_zero;
            OP_BLTZ: cond = d1_neg;
            OP_BGEZ: cond = !d1_neg;
            OP_BLTU: cond = lt_u;
            OP_BGEU: cond = !lt_u;
            default: cond = 1'b0;
        endcase
    end

    assign capture = !flush && !stall;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            out_valid <= 1'b0;
            out_op    <= 3'd0;
            isEqual   <= 1'b0;
            isLess    <= 1'b0;
            taken     <= 1'b0;
        end else if (!stall) begin
            // Flags are qualified so an idle slot never looks like a taken branch.
            out_valid <= in_valid;
            out_op    <= op;
            isEqual   <= in_valid && eq;
            isLess    <= in_valid && lt_s;
            taken     <= in_valid && cond;
        end
    end

`ifdef BRANCH_CMP_STATS_EN
    always_ff @(posedge clk) begin
        if (reset || cnt_clear) begin
            branch_count <= '0;
            taken_count  <= '0;
        end else if (capture && in_valid) begin
            if (branch_count != '1) branch_count <= branch_count + 1'b1;
            if (cond && (taken_count != '1)) taken_count <= taken_count + 1'b1;
        end
    end
`else
    logic unused_capture;
    assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_branch_compare_unit.sv
// Scoreboard bench for branch_compare_unit: 32-bit and 8-bit instances against a spec-level model.
module tb_branch_compare_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid;
    logic [2:0]  op;
    logic [31:0] data1;
    logic [31:0] data2;
    logic        stall;
    logic        flush;
    logic        cnt_clear;

    logic        ov_a, eq_a, lt_a, tk_a;
    logic [2:0]  op_a;
    logic        ov_b, eq_b, lt_b, tk_b;
    logic [2:0]  op_b;
`ifdef BRANCH_CMP_STATS_EN
    logic [15:0] bc_a, tc_a;
    logic [3:0]  bc_b, tc_b;
`endif

    branch_compare_unit #(.WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .op(op),
        .data1(data1), .data2(data2), .stall(stall), .flush(flush),
        .out_valid(ov_a), .out_op(op_a), .isEqual(eq_a), .isLess(lt_a),
`ifdef BRANCH_CMP_STATS_EN
        .cnt_clear(cnt_clear), .branch_count(bc_a), .taken_count(tc_a),
`endif
        .taken(tk_a)
    );

    branch_compare_unit #(.WIDTH(8), .CNT_WIDTH(4)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .op(op),
        .data1(data1[7:0]), .data2(data2[7:0]), .stall(stall), .flush(flush),
        .out_valid(ov_b), .out_op(op_b), .isEqual(eq_b), .isLess(lt_b),
`ifdef BRANCH_CMP_STATS_EN
        .cnt_clear(cnt_clear), .branch_count(bc_b), .taken_count(tc_b),
`endif
        .taken(tk_b)
    );

    typedef struct {
        bit       v;
        bit [2:0] op;
        bit       eq;
        bit       lt;
        bit       tk;
        int       bc;
        int       tc;
    } st_t;

    typedef struct {
        st_t a;
        st_t b;
    } exp_t;

    exp_t q[$];
    st_t  cur_a;
    st_t  cur_b;
    int   n_vec = 0;
    int   errs  = 0;

    // Branch conditions from plain signed/unsigned arithmetic on a w-bit view of the operands.
    function automatic void ref_eval(input int w, input bit [2:0] o, input logic [31:0] d1,
                                     input logic [31:0] d2, output bit e, output bit l, output bit t);
        longint unsigned m  = (64'd1 << w) - 1;
        longint unsigned ua = longint'(d1) & m;
        longint unsigned ub = longint'(d2) & m;
        longint sa = longint'(ua) - ((((ua >> (w - 1)) & 1) != 0) ? (longint'(1) << w) : 0);
        longint sb = longint'(ub) - ((((ub >> (w - 1)) & 1) != 0) ? (longint'(1) << w) : 0);
        e = (ua == ub);
        l = (sa < sb);
        case (o)
            3'd0: t = (ua == ub);
            3'd1: t = (ua != ub);
            3'd2: t = (sa <= 0);
            3'd3: t = (sa > 0);
            3'd4: t = (sa < 0);
            3'd5: t = (sa >= 0);
            3'd6: t = (ua < ub);
            default: t = (ua >= ub);
        endcase
    endfunction

    function automatic st_t step(input st_t cur, input int w, input int cmax, input bit rst,
                                 input bit iv, input bit [2:0] o, input logic [31:0] d1,
                                 input logic [31:0] d2, input bit st, input bit fl, input bit clr);
        st_t nx;
        st_t zero;
        bit e, l, t;
        nx = cur;
        ref_eval(w, o, d1, d2, e, l, t);
        if (rst) begin
            nx = zero;
        end else begin
            if (fl) begin
                nx = zero;
                nx.bc = cur.bc;
                nx.tc = cur.tc;
            end else if (!st) begin
                nx.v  = iv;
                nx.op = o;
                nx.eq = iv && e;
                nx.lt = iv && l;
                nx.tk = iv && t;
            end
            if (clr) begin
                nx.bc = 0;
                nx.tc = 0;
            end else if (!fl && !st && iv) begin
                if (cur.bc < cmax) nx.bc = cur.bc + 1;
                if (t && cur.tc < cmax) nx.tc = cur.tc + 1;
            end
        end
        return nx;
    endfunction

    task automatic drive(input bit rst, input bit iv, input bit [2:0] o, input logic [31:0] d1,
                         input logic [31:0] d2, input bit st, input bit fl, input bit clr);
        exp_t e;
        @(negedge clk);
        reset     = rst;
        in_valid  = iv;
        op        = o;
        data1     = d1;
        data2     = d2;
        stall     = st;
        flush     = fl;
        cnt_clear = clr;
        cur_a = step(cur_a, 32, 65535, rst, iv, o, d1, d2, st, fl, clr);
        cur_b = step(cur_b, 8, 15, rst, iv, o, d1, d2, st, fl, clr);
        e.a = cur_a;
        e.b = cur_b;
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: one expected state per clock edge, compared just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                n_vec++;
                chk("w32 out_valid", 64'(ov_a), 64'(e.a.v));
                chk("w32 out_op",    64'(op_a), 64'(e.a.op));
                chk("w32 isEqual",   64'(eq_a), 64'(e.a.eq));
                chk("w32 isLess",    64'(lt_a), 64'(e.a.lt));
                chk("w32 taken",     64'(tk_a), 64'(e.a.tk));
                chk("w8 out_valid",  64'(ov_b), 64'(e.b.v));
                chk("w8 out_op",     64'(op_b), 64'(e.b.op));
                chk("w8 isEqual",    64'(eq_b), 64'(e.b.eq));
                chk("w8 isLess",     64'(lt_b), 64'(e.b.lt));
                chk("w8 taken",      64'(tk_b), 64'(e.b.tk));
`ifdef BRANCH_CMP_STATS_EN
                chk("w32 branch_count", 64'(bc_a), 64'(e.a.bc));
                chk("w32 taken_count",  64'(tc_a), 64'(e.a.tc));
                chk("w8 branch_count",  64'(bc_b), 64'(e.b.bc));
                chk("w8 taken_count",   64'(tc_b), 64'(e.b.tc));
`endif
            end
        end
    end

    initial begin
        logic [31:0] specials [6];
        int guard;
        specials = '{32'h0, 32'h1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7F, 32'h80};

        // Reset held with a live BEQ 5/5, then the first capture.
        drive(1, 1, 3'd0, 32'd5, 32'd5, 0, 0, 0);
        drive(1, 1, 3'd0, 32'd5, 32'd5, 0, 0, 0);
        drive(0, 1, 3'd0, 32'd5, 32'd5, 0, 0, 0);

        // Every op against the most-negative operand, then zero.
        for (int o = 0; o < 8; o++) drive(0, 1, 3'(o), 32'h8000_0000, 32'd1, 0, 0, 0);
        for (int o = 0; o < 8; o++) drive(0, 1, 3'(o), 32'd0, 32'd0, 0, 0, 0);
        drive(0, 1, 3'd6, 32'd9, 32'd9, 0, 0, 0);
        drive(0, 1, 3'd7, 32'd9, 32'd9, 0, 0, 0);

        // 8-bit sign boundaries.
        drive(0, 1, 3'd3, 32'h7F, 32'd0, 0, 0, 0);
        drive(0, 1, 3'd3, 32'h80, 32'd0, 0, 0, 0);
        drive(0, 1, 3'd7, 32'h80, 32'h7F, 0, 0, 0);

        // Stall holds a taken BEQ; stall+flush clears.
        drive(0, 1, 3'd0, 32'd24, 32'd24, 0, 0, 0);
        repeat (3) drive(0, 1, 3'd0, 32'd52, 32'd24, 1, 0, 0);
        drive(0, 1, 3'd0, 32'd24, 32'd24, 1, 1, 0);

        // Invalid slot, then reset during stall.
        drive(0, 0, 3'd0, 32'd78, 32'd78, 0, 0, 0);
        drive(0, 1, 3'd1, 32'd3, 32'd4, 0, 0, 0);
        drive(1, 1, 3'd1, 32'd3, 32'd4, 1, 1, 0);

        // Counter saturation and clear alongside a valid capture.
        repeat (20) drive(0, 1, 3'd0, 32'd11, 32'd11, 0, 0, 0);
        drive(0, 1, 3'd0, 32'd11, 32'd11, 1, 0, 0);
        drive(0, 1, 3'd0, 32'd11, 32'd11, 0, 0, 1);
        drive(0, 1, 3'd0, 32'd11, 32'd11, 0, 0, 0);
        drive(0, 1, 3'd0, 32'd11, 32'd11, 1, 0, 1);

        // Randomized traffic with occasional control events.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] d1, d2;
            d1 = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            case ($urandom_range(0, 3))
                0: d2 = d1;
                1: d2 = specials[$urandom_range(0, 5)];
                default: d2 = $urandom;
            endcase
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                  d1, d2, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 39) == 0);
        end

        guard = 0;
        while (q.size() != 0 && guard < 50) begin
            @(posedge clk);
            #2;
            guard++;
        end
        if (q.size() != 0) begin
            errs++;
            $display("FAIL drain: %0d results pending, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, errs);
        $finish;
    end

endmodule
